// File: rtl/logic_unit_if.sv
// Operand/result bus for logic_unit: valid/ready input beats in, valid/ready
// registered result with flags out.
interface logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_mode;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             all_ones;

  modport master (
    output in_valid, a, b, op, acc_mode, last, out_ready,
    input  in_ready, out_valid, result, zero, all_ones
  );

  modport slave (
    input  in_valid, a, b, op, acc_mode, last, out_ready,
    output in_ready, out_valid, result, zero, all_ones
  );
endinterface

// File: rtl/logic_unit.sv
// Registered bitwise logic unit with valid/ready handshake and a multi-beat
// accumulate mode that folds a packet of operands into one flagged result.
module logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  logic_unit_if.slave  bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic             all_ones_q, all_ones_d;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_val;

  function automatic logic [WIDTH-1:0] bitop(input logic [2:0] op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x & y);
      3'b100:  r = ~(x | y);
      3'b101:  r = ~(x ^ y);
      3'b110:  r = x & ~y;
      default: r = x;
    endcase
    return r;
  endfunction

  // Ready gates on rst so no beat is accepted while the unit is held in reset.
  assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    load     = 1'b0;
    load_val = result_q;
    if (accept) begin
      if (state_q == IDLE) begin
        if (!bus.acc_mode) begin
          load     = 1'b1;
          load_val = bitop(bus.op, bus.a, bus.b);
        end else if (bus.last) begin
          load     = 1'b1;
          load_val = bus.a;
        end else begin
          acc_d   = bus.a;
          state_d = ACCUM;
        end
      end else begin
        if (bus.last) begin
          load     = 1'b1;
          load_val = bitop(bus.op, acc_q, bus.a);
          state_d  = IDLE;
        end else begin
          acc_d = bitop(bus.op, acc_q, bus.a);
        end
      end
    end
  end

  // Flags come from the value being loaded so they align with result.
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    all_ones_d  = all_ones_q;
    out_valid_d = out_valid_q;
    if (load) begin
      result_d    = load_val;
      zero_d      = ~|load_val;
      all_ones_d  = &load_val;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b1;
      all_ones_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      all_ones_q  <= all_ones_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.all_ones  = all_ones_q;

endmodule

// File: doc/logic_unit.md
# logic_unit

Parametrised, registered bitwise logic unit: the successor to the single-bit AND cell. It applies one of eight bitwise operations to two WIDTH-bit operands and delivers the result through a valid/ready output register. An accumulate mode folds a multi-beat packet of operands into one result. It sits between operand producers and result consumers on the datapath, wherever a stallable, flag-producing logic stage is needed.

## Interface
- WIDTH, 8, operand and result width in bits; legal values are 1 to 64.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat is presented.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored in accumulate mode.
- op  input  3  operation select, sampled on each accepted beat.
- acc_mode  input  1  accumulate mode, sampled only on the first beat of a packet.
- last  input  1  final beat of an accumulate packet; ignored when the packet is not in accumulate mode.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered; high when result is all zeros.
- all_ones  output  1  registered; high when result is all ones.

## Operation
- Operation codes, where x is the first operand and y the second:
  - 000: x & y.
  - 001: x | y.
  - 010: x ^ y.
  - 011: ~(x & y).
  - 100: ~(x | y).
  - 101: ~(x ^ y).
  - 110: x & ~y.
  - 111: x, pass-through.
- Accept: a beat is accepted when in_valid && in_ready.
- in_ready = !rst && (!out_valid || out_ready). This rule applies in every state, including non-last accumulate beats.
- The state machine has two states, IDLE and ACCUM, plus a WIDTH-bit accumulator register acc.
- IDLE, accepted beat with acc_mode=0:
  - result <= f(a, b).
  - out_valid <= 1.
  - State stays IDLE.
- IDLE, accepted beat with acc_mode=1 and last=1:
  - result <= a.
  - out_valid <= 1.
  - State stays IDLE.
- IDLE, accepted beat with acc_mode=1 and last=0:
  - acc <= a.
  - State goes to ACCUM.
  - No output is produced.
- ACCUM, accepted beat with last=0:
  - acc <= f(acc, a), using that beat's op.
  - acc_mode is ignored.
- ACCUM, accepted beat with last=1:
  - result <= f(acc, a).
  - out_valid <= 1.
  - State goes to IDLE.
- Output drain: when out_valid && out_ready and no new output is loaded that cycle, out_valid <= 0.
- Simultaneous drain and load: the new output loads and out_valid stays 1.
- result, zero and all_ones change only when a new output loads. They hold while out_valid=1 and out_ready=0.
- zero and all_ones are computed from the value being loaded into result. They are never decoded from the result register itself.
- No arithmetic is performed. All operations are bitwise and width-preserving; there is no carry or overflow.

## Timing
- Reset values:
  - out_valid=0.
  - result=0.
  - zero=1.
  - all_ones=0.
  - acc=0.
  - State IDLE.
  - in_ready=0 while rst is high, and 1 in the first cycle after release.
- Reset mid-packet: the unit returns to IDLE immediately and the partial accumulator is discarded. The next accepted beat starts a new packet.
- Latency: an accepted output-producing beat gives out_valid=1 on the next clock edge.
- Throughput: one beat per cycle when out_ready is held high.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0. No beat is lost and result is stable.
- WIDTH=1: zero and all_ones are mutually exclusive inverses.

## Test plan
- Reset and single op, WIDTH=8: after reset, check out_valid=0, result=0x00, zero=1. Then send a=0xF0, b=0x3C, op=000, out_ready=1 → next cycle result=0x30, out_valid=1, zero=0, all_ones=0.
- Op sweep: send a=0xA5, b=0x0F through op 000 to 111 back-to-back with out_ready=1 → results 0x05, 0xAF, 0xAA, 0xFA, 0x50, 0x55, 0xA0, 0xA5 on consecutive cycles. Also check flags on a=0xFF, b=0xFF, op=000 → all_ones=1.
- Accumulate XOR: send a packet of 0x12, 0x34, 0x56 with acc_mode=1 on the first beat, op=010, last on the third beat → exactly one output, 0x70, one cycle after the last beat. No out_valid during the first two beats.
- Single-beat accumulate: send a=0x9C with acc_mode=1, last=1, op=000 → result=0x9C, and state remains IDLE.
- Backpressure: hold out_ready=0 after the first output of a back-to-back stream → in_ready=0 and result stable for 5 cycles. Release → the remaining outputs arrive in order with no loss or duplication.
- Mid-packet reset: after 2 non-last beats of an OR packet (0x01, 0x02), pulse rst asynchronously between clock edges → outputs return to reset values at once. A new packet 0x40 with last=1 yields exactly 0x40, not 0x43.
